bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3), one bit per clock.

---
 rtl/bin2bcd_seq_if.sv | 26 ++
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 tb/tb_bin2bcd_seq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and digit bus between a binary-count source and bin2bcd_seq.
// master: drives start/bin and consumes the digits.
// slave:  the converter side.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
) ();
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       num1;
  logic [3:0]       num2;
  logic [3:0]       num3;
  logic [3:0]       num4;
  logic             ovf;

  modport master (
    output start, bin,
    input  busy, done, num1, num2, num3, num4, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, num1, num2, num3, num4, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Feeds the 4-digit tube driver; the digit outputs only change on the done
// cycle, so the scan driver never displays a partial result.
// Optional macro BIN2BCD_SAT_EN: values above 9999 show 9,9,9,9 instead of
// the value mod 10000. ovf reports > 9999 in both builds.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input logic         clk,
  input logic         rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int IW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    iter_q;
  logic [BIN_W-1:0] bin_sh_q;
  logic [19:0]      bcd_q;
  logic [19:0]      bcd_adj;
  logic [20:0]      bcd_shl;
  logic             last_iter;
  logic             ovf_nxt;
  logic [15:0]      dig_nxt;
  logic [15:0]      dig_q;
  logic             ovf_q;

  assign last_iter = (iter_q == IW'(BIN_W - 1));

  // Add-3 correction on every nibble >= 5, then shift in the next binary bit.
  // The shifted vector keeps a 21st bit so the ovf test covers everything
  // that can leave the top nibble.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shl = {bcd_adj, bin_sh_q[BIN_W-1]};
    ovf_nxt = (bcd_shl[20:16] != 5'd0);
`ifdef BIN2BCD_SAT_EN
    dig_nxt = ovf_nxt ? 16'h9999 : bcd_shl[15:0];
`else
    dig_nxt = bcd_shl[15:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift while in SHIFT. The result registers
  // load on the final shift edge so they are already valid during the DONE
  // cycle, which is when done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q   <= '0;
      bin_sh_q <= '0;
      bcd_q    <= '0;
      dig_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_sh_q <= bus.bin;
            bcd_q    <= '0;
            iter_q   <= '0;
          end
        end
        SHIFT: begin
          bcd_q    <= bcd_shl[19:0];
          bin_sh_q <= bin_sh_q << 1;
          iter_q   <= iter_q + 1'b1;
          if (last_iter) begin
            dig_q <= dig_nxt;
            ovf_q <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.num1 = dig_q[15:12];
  assign bus.num2 = dig_q[11:8];
  assign bus.num3 = dig_q[7:4];
  assign bus.num4 = dig_q[3:0];
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BIN_W = 14). Expected digits come from
// a decimal div/mod model pushed to a queue at start and popped at done.
// Timing: start accepted at edge k; done is high between edges k+14 and k+15
// (cycle k+15), i.e. sampled at the negedge following edge k+14.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bin2bcd_seq_if #(.BIN_W(BIN_W)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  // {num1,num2,num3,num4,ovf}
  function automatic logic [16:0] model(input int v);
    logic [3:0] d1, d2, d3, d4;
    logic       o;
    d4 = 4'(v % 10);
    d3 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 1000) % 10);
    o  = (v > 9999);
`ifdef BIN2BCD_SAT_EN
    if (o) begin
      d1 = 4'd9; d2 = 4'd9; d3 = 4'd9; d4 = 4'd9;
    end
`endif
    return {d1, d2, d3, d4, o};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.num1, bus.num2, bus.num3, bus.num4, bus.ovf};
  endfunction

  // Drive start for one cycle at a negedge; returns at the negedge after the
  // accepting edge.
  task automatic start_conv(input int v, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = BIN_W'(v);
    if (push) exp_q.push_back(model(v));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges until done is seen; lat = -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.bin   = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctl: busy/done=%b expected 00", {bus.busy, bus.done});
    end
    checks++;
    if (observed() !== 17'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", observed(), 17'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [16:0] e;
    start_conv(1234, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b expected 1", bus.busy);
    end
    wait_done(lat);
    checks++;
    if (lat != BIN_W) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, BIN_W);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL basic_1234: got %h expected %h", observed(), e);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL basic_after: busy/done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_values(input string name, input int v);
    int lat;
    logic [16:0] e;
    start_conv(v, 1'b1);
    wait_done(lat);
    checks++;
    if (lat != BIN_W) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, BIN_W);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL %s_%0d: got %h expected %h", name, v, observed(), e);
    end
  endtask

  task automatic test_boundaries();
    test_values("bound", 0);
    test_values("bound", 9999);
    test_values("bound", 10);
    test_values("bound", 1);
    test_values("bound", 1000);
  endtask

  task automatic test_overflow();
    test_values("ovf", 12345);
    test_values("ovf", 16383);
    test_values("ovf", 10000);
  endtask

  task automatic test_ignored_start();
    int lat;
    logic [16:0] e;
    start_conv(42, 1'b1);                // after edge k
    repeat (4) @(negedge clk);           // after edge k+4
    bus.start = 1'b1;                    // sampled at edge k+5 (busy)
    bus.bin   = BIN_W'(777);
    @(negedge clk);                      // after edge k+5
    bus.start = 1'b0;
    bus.bin   = BIN_W'(1);
    wait_done(lat);
    checks++;
    if (lat != BIN_W - 5) begin
      errors++;
      $display("FAIL ign_latency: got %0d expected %0d", lat, BIN_W - 5);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL ign_digits: got %h expected %h", observed(), e);
    end
    // next start sampled at edge k+16 must be accepted
    start_conv(777, 1'b1);
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      errors++;
      $display("FAIL ign_accept: busy/done=%b expected 10", {bus.busy, bus.done});
    end
    wait_done(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    checks++;
    if (observed() !== e || lat != BIN_W) begin
      errors++;
      $display("FAIL ign_second: got %h lat %0d expected %h lat %0d", observed(), lat, e, BIN_W);
    end
  endtask

  task automatic test_hold();
    logic [16:0] snap;
    logic        bad;
    snap = model(777);
    bad  = 1'b0;
    bus.bin = BIN_W'(5555);
    repeat (6) begin
      @(negedge clk);
      if (observed() !== snap || bus.done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL hold: got %h done %b expected %h done 0", observed(), bus.done, snap);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [16:0] e;
    logic        saw_done;
    start_conv(5678, 1'b0);              // after edge k
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b0;                        // mid-conversion, cycle 7
    #1;
    checks++;
    if ({bus.busy, bus.done, observed()} !== 19'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h expected %h", {bus.busy, bus.done, observed()}, 19'h0);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nodone: got done pulse expected none");
    end
    checks++;
    if (observed() !== 17'h0) begin
      errors++;
      $display("FAIL rstmid_digits: got %h expected %h", observed(), 17'h0);
    end
    start_conv(5678, 1'b1);
    wait_done(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    checks++;
    if (observed() !== e || lat != BIN_W) begin
      errors++;
      $display("FAIL rstmid_after: got %h lat %0d expected %h lat %0d", observed(), lat, e, BIN_W);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int v;
    logic [16:0] e;
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 16383));
      start_conv(v, 1'b1);
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept_%0d: busy=%b expected 1", i, bus.busy);
      end
      wait_done(lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
      checks++;
      if (observed() !== e || lat != BIN_W) begin
        errors++;
        $display("FAIL b2b_%0d(%0d): got %h lat %0d expected %h lat %0d", i, v, observed(), lat, e, BIN_W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignored_start();
    test_hold();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
